// File: rtl/snn_config_loader_pkg.sv
// Shared widths, byte offsets, FSM encoding and configuration types for the SNN config loader.
// SNN_CFG_CHECKSUM_EN adds a trailing XOR checksum byte to every load.
package snn_cfg_pkg;

   localparam int W_WEIGHTS = 320;
   localparam int W_DELAYS  = 640;
   localparam int NUM_BYTES = 123;

   localparam int OFF_WEIGHTS = 0;
   localparam int OFF_DELAYS  = 40;
   localparam int OFF_THR     = 120;
   localparam int OFF_DECAY   = 121;
   localparam int OFF_REFR    = 122;

   localparam int N_WEIGHT_BYTES = W_WEIGHTS / 8;
   localparam int N_DELAY_BYTES  = W_DELAYS / 8;

   localparam int W_THR   = 5;
   localparam int W_DECAY = 3;
   localparam int W_REFR  = 5;
   localparam int PTR_W   = 7;

   // Index of the byte whose acceptance ends the load phase.
`ifdef SNN_CFG_CHECKSUM_EN
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BYTES);
`else
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BYTES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   typedef logic [NUM_BYTES-1:0][7:0] shadow_t;

   typedef struct packed {
      logic [W_WEIGHTS-1:0] weights;
      logic [W_DELAYS-1:0]  delays;
      logic [W_THR-1:0]     threshold;
      logic [W_DECAY-1:0]   decay;
      logic [W_REFR-1:0]    refractory_period;
   } cfg_t;

   function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/snn_config_loader_if.sv
// Byte-stream and configuration-output bundle between the upstream host (master) and the loader (slave).
interface snn_config_loader_if;

   logic                               load_start;
   logic [7:0]                         byte_in;
   logic                               byte_valid;
   logic                               byte_ready;
   logic                               net_enable_in;
   logic                               enable_out;
   logic [snn_cfg_pkg::W_WEIGHTS-1:0]  weights;
   logic [snn_cfg_pkg::W_DELAYS-1:0]   delays;
   logic [snn_cfg_pkg::W_THR-1:0]      threshold;
   logic [snn_cfg_pkg::W_DECAY-1:0]    decay;
   logic [snn_cfg_pkg::W_REFR-1:0]     refractory_period;
   logic                               config_valid;
   logic                               load_busy;
   logic                               load_error;

   modport master (
      output load_start, byte_in, byte_valid, net_enable_in,
      input  byte_ready, enable_out, weights, delays, threshold, decay,
             refractory_period, config_valid, load_busy, load_error
   );

   modport slave (
      input  load_start, byte_in, byte_valid, net_enable_in,
      output byte_ready, enable_out, weights, delays, threshold, decay,
             refractory_period, config_valid, load_busy, load_error
   );

endinterface

// File: rtl/snn_config_loader_unpack.sv
// Combinational mapping of the shadow byte array onto the typed configuration fields.
module snn_cfg_unpack
   import snn_cfg_pkg::*;
(
   input  shadow_t i_shadow,
   output cfg_t    o_cfg
);

   logic [W_WEIGHTS-1:0] w_weights;
   logic [W_DELAYS-1:0]  w_delays;
   logic                 w_unused_bits;

   genvar gi;
   generate
      for (gi = 0; gi < N_WEIGHT_BYTES; gi++) begin : g_weights
         assign w_weights[8*gi +: 8] = i_shadow[OFF_WEIGHTS + gi];
      end
      for (gi = 0; gi < N_DELAY_BYTES; gi++) begin : g_delays
         assign w_delays[8*gi +: 8] = i_shadow[OFF_DELAYS + gi];
      end
   endgenerate

   // Upper bits of the scalar parameter bytes carry no meaning.
   assign w_unused_bits = ^{i_shadow[OFF_THR][7:W_THR],
                            i_shadow[OFF_DECAY][7:W_DECAY],
                            i_shadow[OFF_REFR][7:W_REFR]};

   always_comb begin
      o_cfg.weights           = w_weights;
      o_cfg.delays            = w_delays;
      o_cfg.threshold         = i_shadow[OFF_THR][W_THR-1:0];
      o_cfg.decay             = i_shadow[OFF_DECAY][W_DECAY-1:0];
      o_cfg.refractory_period = i_shadow[OFF_REFR][W_REFR-1:0];
   end

endmodule

// File: rtl/snn_config_loader.sv
// Byte-serial SNN configuration loader: shadow store, atomic commit, enable gating.
// Optional SNN_CFG_CHECKSUM_EN: trailing XOR checksum byte; mismatch aborts the commit.
module snn_config_loader
   import snn_cfg_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   snn_config_loader_if.slave bus
);

   state_t           r_state;
   state_t           w_next_state;
   logic [PTR_W-1:0] r_ptr;
   shadow_t          r_shadow;
   cfg_t             r_active;
   cfg_t             w_unpacked;
   logic             r_cfg_valid;

   logic w_byte_ready;
   logic w_busy;
   logic w_accept;
   logic w_restart;
   logic w_commit;
   logic w_cks_fail;
   logic w_cks_ok;

`ifdef SNN_CFG_CHECKSUM_EN
   logic [7:0] r_xor;
   logic       r_load_error;

   // Correct checksum byte makes the running XOR over all bytes zero.
   assign w_cks_ok = (xor_acc(r_xor, bus.byte_in) == 8'h00);
`else
   logic w_unused_cks;

   assign w_cks_ok     = 1'b1;
   assign w_unused_cks = w_cks_fail;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_byte_ready = 1'b0;
      w_busy       = 1'b0;
      w_accept     = 1'b0;
      w_restart    = 1'b0;
      w_commit     = 1'b0;
      w_cks_fail   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.load_start) begin
               w_restart    = 1'b1;
               w_next_state = LOAD;
            end
         end
         LOAD: begin
            w_byte_ready = 1'b1;
            w_busy       = 1'b1;
            // A restart wins over a simultaneous byte, which is dropped.
            if (bus.load_start) begin
               w_restart = 1'b1;
            end else if (bus.byte_valid) begin
               w_accept = 1'b1;
               if (r_ptr == LAST_PTR) begin
                  if (w_cks_ok) begin
                     w_next_state = COMMIT;
                  end else begin
                     w_cks_fail   = 1'b1;
                     w_next_state = IDLE;
                  end
               end
            end
         end
         COMMIT: begin
            w_busy       = 1'b1;
            w_commit     = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_restart) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= r_ptr + PTR_W'(1);
      end
   end

   // The checksum byte lands at an index beyond the array and is never stored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
      end else begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_accept && (r_ptr == PTR_W'(i))) begin
               r_shadow[i] <= bus.byte_in;
            end
         end
      end
   end

`ifdef SNN_CFG_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_xor        <= 8'h00;
         r_load_error <= 1'b0;
      end else if (w_restart) begin
         r_xor        <= 8'h00;
         r_load_error <= 1'b0;
      end else begin
         if (w_accept) begin
            r_xor <= xor_acc(r_xor, bus.byte_in);
         end
         if (w_cks_fail) begin
            r_load_error <= 1'b1;
         end
      end
   end

   assign bus.load_error = r_load_error;
`else
   assign bus.load_error = 1'b0;
`endif

   snn_cfg_unpack u_unpack (
      .i_shadow (r_shadow),
      .o_cfg    (w_unpacked)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_active    <= '0;
         r_cfg_valid <= 1'b0;
      end else if (w_commit) begin
         r_active    <= w_unpacked;
         r_cfg_valid <= 1'b1;
      end
   end

   assign bus.byte_ready        = w_byte_ready;
   assign bus.load_busy         = w_busy;
   assign bus.config_valid      = r_cfg_valid;
   assign bus.enable_out        = bus.net_enable_in & r_cfg_valid;
   assign bus.weights           = r_active.weights;
   assign bus.delays            = r_active.delays;
   assign bus.threshold         = r_active.threshold;
   assign bus.decay             = r_active.decay;
   assign bus.refractory_period = r_active.refractory_period;

endmodule

// File: tb/tb_snn_config_loader.sv
// Randomized bench for snn_config_loader against a transaction-level model of the load/commit rules.
module tb_snn_config_loader;
   import snn_cfg_pkg::*;

`ifdef SNN_CFG_CHECKSUM_EN
   localparam int N_LOAD = NUM_BYTES + 1;
   localparam bit CKS    = 1'b1;
`else
   localparam int N_LOAD = NUM_BYTES;
   localparam bit CKS    = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   snn_config_loader_if bus ();

   snn_config_loader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: loading phase, byte count, shadow contents, committed contents.
   logic [7:0] m_shadow [NUM_BYTES];
   logic [7:0] m_act    [NUM_BYTES];
   logic [7:0] m_xor;
   bit         m_valid, m_loading, m_pending, m_err;
   int         m_cnt;

   logic [7:0] pay [NUM_BYTES+1];

   task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_BYTES; k++) begin
         m_shadow[k] = 8'h00;
         m_act[k]    = 8'h00;
      end
      m_xor = 8'h00; m_valid = 0; m_loading = 0; m_pending = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input bit ls, input bit bv, input logic [7:0] b);
      if (m_pending) begin
         m_act     = m_shadow;
         m_valid   = 1;
         m_pending = 0;
      end else if (!m_loading) begin
         if (ls) begin
            m_loading = 1; m_cnt = 0; m_xor = 8'h00; m_err = 0;
         end
      end else if (ls) begin
         m_cnt = 0; m_xor = 8'h00; m_err = 0;
      end else if (bv) begin
         if (m_cnt < NUM_BYTES) m_shadow[m_cnt] = b;
         m_xor = m_xor ^ b;
         m_cnt++;
         if (m_cnt == N_LOAD) begin
            m_loading = 0;
            if (CKS && m_xor != 8'h00) m_err = 1;
            else m_pending = 1;
         end
      end
   endtask

   task automatic check_all(input string ph);
      logic [W_WEIGHTS-1:0] ew;
      logic [W_DELAYS-1:0]  ed;
      for (int k = 0; k < N_WEIGHT_BYTES; k++) ew[8*k +: 8] = m_act[k];
      for (int k = 0; k < N_DELAY_BYTES; k++)  ed[8*k +: 8] = m_act[40 + k];
      check({ph, "_weights"}, bus.weights, ew);
      check({ph, "_delays"}, bus.delays, ed);
      check({ph, "_thr"}, bus.threshold, m_act[120][4:0]);
      check({ph, "_decay"}, bus.decay, m_act[121][2:0]);
      check({ph, "_refr"}, bus.refractory_period, m_act[122][4:0]);
      check({ph, "_ready"}, bus.byte_ready, m_loading);
      check({ph, "_busy"}, bus.load_busy, m_loading | m_pending);
      check({ph, "_valid"}, bus.config_valid, m_valid);
      check({ph, "_enable"}, bus.enable_out, bus.net_enable_in & m_valid);
      check({ph, "_error"}, bus.load_error, m_err);
   endtask

   task automatic cycle(input bit ls, input bit bv, input logic [7:0] b);
      bus.load_start    = ls;
      bus.byte_valid    = bv;
      bus.byte_in       = b;
      bus.net_enable_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_edge(ls, bv, b);
      #1;
      check_all("cyc");
      bus.load_start = 1'b0;
      bus.byte_valid = 1'b0;
   endtask

   task automatic do_reset(input int ncyc);
      bus.load_start    = 1'b0;
      bus.byte_valid    = 1'b0;
      bus.byte_in       = 8'h00;
      bus.net_enable_in = 1'b1;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("rst");
      repeat (ncyc) begin
         @(posedge clk);
         #1;
         check_all("rst");
      end
      reset = 1'b0;
   endtask

   task automatic fill_cks(input logic [7:0] delta);
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < NUM_BYTES; k++) x = x ^ pay[k];
      pay[NUM_BYTES] = x ^ delta;
   endtask

   task automatic send_load(input bit gapped, input bit rgap, input int restart_at, input int abort_at);
      bit restarted;
      bit bv;
      int guard;
      restarted = 0;
      guard     = 0;
      cycle(1'b1, 1'b0, 8'h00);
      while (m_loading && guard < 3000) begin
         guard++;
         if (m_cnt == abort_at) begin
            do_reset(2);
            return;
         end
         if (m_cnt == restart_at && !restarted) begin
            restarted = 1;
            cycle(1'b1, 1'b1, pay[m_cnt]);
         end else begin
            if (gapped)    bv = (guard % 2) == 1;
            else if (rgap) bv = $urandom_range(0, 3) != 0;
            else           bv = 1'b1;
            cycle(1'b0, bv, pay[m_cnt]);
         end
      end
      check("load_bound", guard < 3000, 1'b1);
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset             = 1'b0;
      bus.load_start    = 1'b0;
      bus.byte_valid    = 1'b0;
      bus.byte_in       = 8'h00;
      bus.net_enable_in = 1'b1;
      #2;
      do_reset(3);
      check("t1_enable_in_reset", bus.enable_out, 1'b0);

      // Full load of k = k
      for (int k = 0; k < NUM_BYTES; k++) pay[k] = 8'(k);
      fill_cks(8'h00);
      send_load(1'b0, 1'b0, -1, -1);
      check("t2_w_lo", bus.weights[7:0], 8'h00);
      check("t2_w_hi", bus.weights[319:312], 8'h27);
      check("t2_d_lo", bus.delays[7:0], 8'h28);
      check("t2_thr", bus.threshold, 5'h18);
      check("t2_decay", bus.decay, 3'd1);
      check("t2_refr", bus.refractory_period, 5'h1A);
      check("t2_valid", bus.config_valid, 1'b1);

      // Gapped stream, same payload
      send_load(1'b1, 1'b0, -1, -1);
      check("t3_d_hi", bus.delays[639:632], 8'h77);

      // Restart at byte 50, then all-ones payload
      for (int k = 0; k < NUM_BYTES; k++) pay[k] = 8'hFF;
      fill_cks(8'h00);
      send_load(1'b0, 1'b0, 50, -1);
      check("t4_weights", bus.weights, {W_WEIGHTS{1'b1}});
      check("t4_thr", bus.threshold, 5'd31);
      check("t4_decay", bus.decay, 3'd7);

      // Reset in the middle of a reload, then stray bytes in IDLE
      for (int k = 0; k < NUM_BYTES; k++) pay[k] = 8'($urandom_range(0, 255));
      fill_cks(8'h00);
      send_load(1'b0, 1'b1, -1, 60);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hA5);
      check("t5_valid", bus.config_valid, 1'b0);
      check("t5_weights", bus.weights, '0);

`ifdef SNN_CFG_CHECKSUM_EN
      // Good load, then a corrupted checksum, then a corrected reload
      send_load(1'b0, 1'b1, -1, -1);
      for (int k = 0; k < NUM_BYTES; k++) pay[k] = 8'($urandom_range(0, 255));
      fill_cks(8'h01);
      send_load(1'b0, 1'b1, -1, -1);
      check("t6_error_set", bus.load_error, 1'b1);
      fill_cks(8'h00);
      send_load(1'b0, 1'b1, -1, -1);
      check("t6_error_clr", bus.load_error, 1'b0);
      check("t6_thr", bus.threshold, pay[120][4:0]);
`endif

      // Random loads with random gaps and occasional restarts
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < NUM_BYTES; k++) pay[k] = 8'($urandom_range(0, 255));
         fill_cks(8'h00);
         send_load(1'b0, 1'b1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NUM_BYTES - 1)) : -1, -1);
         for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
